// File: rtl/background_scroll_ctrl_if.sv
// Bundle between the VGA timing / game FSM side and the background sequencer.
// The master drives draw position and control; the slave returns ROM address and status.
interface background_scroll_ctrl_if #(
  parameter int ADDR_W  = 17,
  parameter int SPEED_W = 4
);
  logic [9:0]         DrawX;
  logic [9:0]         DrawY;
  logic               blank;
  logic               vs;
  logic               run;
  logic [SPEED_W-1:0] speed;
  logic               restart;
  logic [ADDR_W-1:0]  rom_address;
  logic               blank_out;
  logic [8:0]         scroll_x;
  logic [15:0]        frame_cnt;
  logic               running;

  modport master (
    output DrawX, DrawY, blank, vs,
    output run, speed, restart,
    input  rom_address, blank_out,
    input  scroll_x, frame_cnt, running
  );

  modport slave (
    input  DrawX, DrawY, blank, vs,
    input  run, speed, restart,
    output rom_address, blank_out,
    output scroll_x, frame_cnt, running
  );
endinterface

// File: rtl/background_scroll_ctrl.sv
// Horizontally scrolling background sequencer: maps 640x480 draw position
// onto a 2x-downscaled wrapping source image, advancing the offset once per frame.
module background_scroll_ctrl #(
  parameter int SRC_W   = 320,
  parameter int SRC_H   = 240,
  parameter int ADDR_W  = 17,
  parameter int SPEED_W = 4
) (
  input logic vga_clk,
  input logic reset_n,
  background_scroll_ctrl_if.slave bus
);

  typedef enum logic {
    STOPPED = 1'b0,
    RUNNING = 1'b1
  } state_t;

  localparam logic [9:0] W10  = 10'(SRC_W);
  localparam logic [9:0] XMAX = 10'(2 * SRC_W);
  localparam logic [9:0] YMAX = 10'(2 * SRC_H);
  localparam logic [ADDR_W-1:0] WA = ADDR_W'(SRC_W);

  state_t state_q;
  state_t state_d;
  logic   running;

  logic               vs_q;
  logic               fb;
  logic [15:0]        frame_q;
  logic [SPEED_W-1:0] speed_q;
  logic               restart_pend;
  logic [8:0]         scroll_q;
  logic [8:0]         scroll_adv;
  logic [9:0]         sum;

  logic [8:0]         sx;
  logic [8:0]         sy;
  logic [9:0]         col_raw;
  logic [9:0]         col;
  logic [ADDR_W-1:0]  addr_d;
  logic [ADDR_W-1:0]  addr_q;
  logic [1:0]         blank_pipe;

  // Falling edge of vs marks the single frame boundary.
  assign fb = vs_q & ~bus.vs;

  // FSM state register.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= STOPPED;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: run is only sampled on a frame boundary.
  always_comb begin
    state_d = state_q;
    if (fb) begin
      case (state_q)
        STOPPED: if (bus.run)  state_d = RUNNING;
        RUNNING: if (!bus.run) state_d = STOPPED;
        default: state_d = STOPPED;
      endcase
    end
  end

  // FSM outputs.
  always_comb begin
    running = (state_q == RUNNING);
  end

  // Candidate next offset; speed < SRC_W so one subtract wraps.
  always_comb begin
    sum = {1'b0, scroll_q} + 10'(speed_q);
    scroll_adv = scroll_q;
    if (sum >= W10) begin
      scroll_adv = 9'(sum - W10);
    end else begin
      scroll_adv = 9'(sum);
    end
  end

  // Per-frame state: counter, latched speed, restart request, offset.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      vs_q         <= 1'b1;
      frame_q      <= '0;
      speed_q      <= '0;
      restart_pend <= 1'b0;
      scroll_q     <= '0;
    end else begin
      vs_q <= bus.vs;
      if (fb) begin
        frame_q      <= frame_q + 16'd1;
        speed_q      <= bus.speed;
        restart_pend <= 1'b0;
        if (restart_pend || bus.restart) begin
          scroll_q <= '0;
        end else if (state_q == RUNNING) begin
          scroll_q <= scroll_adv;
        end
      end else if (bus.restart) begin
        restart_pend <= 1'b1;
      end
    end
  end

  // Source coordinate with wrapped horizontal offset.
  always_comb begin
    sx      = bus.DrawX[9:1];
    sy      = bus.DrawY[9:1];
    col_raw = {1'b0, sx} + {1'b0, scroll_q};
    col     = col_raw;
    if (col_raw >= W10) begin
      col = col_raw - W10;
    end
    addr_d = ADDR_W'(sy) * WA + ADDR_W'(col);
    if (bus.DrawX >= XMAX || bus.DrawY >= YMAX) begin
      addr_d = '0;
    end
  end

  // ROM address register.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end

  // Two-stage blank delay: address register plus ROM output register.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      blank_pipe <= '0;
    end else begin
      blank_pipe <= {blank_pipe[0], bus.blank};
    end
  end

  assign bus.rom_address = addr_q;
  assign bus.blank_out   = blank_pipe[1];
  assign bus.scroll_x    = scroll_q;
  assign bus.frame_cnt   = frame_q;
  assign bus.running     = running;

endmodule
